wr_combine: RTL and testbench

- Write-combining stage directly upstream of the memory write port. The port's write bus (wr_en/addr/dat) must never carry two successive write pulses to the same address.
- Accepts a stream of write requests and holds the newest one in a single pending entry.
- Merges back-to-back writes to the same address into that entry, and reorders only around a blocked entry.
- Issues writes so that every issued write address differs from the previously issued write address.

---
 rtl/wr_combine_if.sv | 26 ++
 rtl/wr_combine.sv | 132 +++++++++++++
 tb/tb_wr_combine.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wr_combine_if.sv
// Request/issue bus for the write-combining stage: requests in, combined
// memory writes and pending-entry status out.
interface wr_combine_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_dat;
    logic              flush;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dat;
    logic              pend_vld;
    logic              pend_blocked;

    modport master (
        output in_valid, in_addr, in_dat, flush,
        input  wr_en, addr, dat, pend_vld, pend_blocked
    );

    modport slave (
        input  in_valid, in_addr, in_dat, flush,
        output wr_en, addr, dat, pend_vld, pend_blocked
    );
endinterface

// File: rtl/wr_combine.sv
// Write-combining stage: holds one pending write, merges same-address writes
// and never issues two successive writes to the same address.
module wr_combine #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 8
) (
    input  logic         clk,
    input  logic         rst,
    wr_combine_if.slave  bus
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 2) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic              p_vld_q, p_vld_d;
    logic              p_blk_q, p_blk_d;
    logic [ADDR_W-1:0] p_addr_q, p_addr_d;
    logic [DATA_W-1:0] p_dat_q, p_dat_d;
    logic              last_vld_q, last_vld_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic              flush_req_q, flush_req_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dat_q, dat_d;

    logic              issue;
    logic [ADDR_W-1:0] iss_addr;
    logic [DATA_W-1:0] iss_dat;
    logic              idle_run;
    logic              flush_exec;
    logic              flush_clr;
    logic              timeout_hit;

    always_comb begin
        p_vld_d     = p_vld_q;
        p_blk_d     = p_blk_q;
        p_addr_d    = p_addr_q;
        p_dat_d     = p_dat_q;
        last_vld_d  = last_vld_q;
        last_addr_d = last_addr_q;
        issue       = 1'b0;
        iss_addr    = p_addr_q;
        iss_dat     = p_dat_q;

        idle_run    = !bus.in_valid && p_vld_q && !p_blk_q;
        flush_exec  = idle_run && flush_req_q;

        if (bus.in_valid) begin
            if (!p_vld_q) begin
                p_vld_d  = 1'b1;
                p_addr_d = bus.in_addr;
                p_dat_d  = bus.in_dat;
                p_blk_d  = last_vld_q && (bus.in_addr == last_addr_q);
            end else if (bus.in_addr == p_addr_q) begin
                p_dat_d = bus.in_dat;
            end else if (!p_blk_q) begin
                issue    = 1'b1;
                p_addr_d = bus.in_addr;
                p_dat_d  = bus.in_dat;
                p_blk_d  = 1'b0;
            end else begin
                // Blocked entry equals last_addr, so the new address is safe to bypass it.
                issue    = 1'b1;
                iss_addr = bus.in_addr;
                iss_dat  = bus.in_dat;
                p_blk_d  = 1'b0;
            end
        end else if (flush_exec) begin
            issue   = 1'b1;
            p_vld_d = 1'b0;
            p_blk_d = 1'b0;
        end

        if (issue) begin
            last_vld_d  = 1'b1;
            last_addr_d = iss_addr;
        end
    end

    always_comb begin
        flush_clr   = !bus.in_valid && flush_req_q && (!p_vld_q || !p_blk_q);
        timeout_hit = (TIMEOUT > 0) && idle_run && (cnt_q == TO_LAST) && !flush_exec;
        flush_req_d = bus.flush || timeout_hit || (flush_req_q && !flush_clr);

        cnt_d = '0;
        if ((TIMEOUT > 0) && idle_run && !issue) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_comb begin
        wr_en_d = issue;
        addr_d  = issue ? iss_addr : addr_q;
        dat_d   = issue ? iss_dat  : dat_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_vld_q     <= 1'b0;
            p_blk_q     <= 1'b0;
            p_addr_q    <= '0;
            p_dat_q     <= '0;
            last_vld_q  <= 1'b0;
            last_addr_q <= '0;
            flush_req_q <= 1'b0;
            cnt_q       <= '0;
            wr_en_q     <= 1'b0;
            addr_q      <= '0;
            dat_q       <= '0;
        end else begin
            p_vld_q     <= p_vld_d;
            p_blk_q     <= p_blk_d;
            p_addr_q    <= p_addr_d;
            p_dat_q     <= p_dat_d;
            last_vld_q  <= last_vld_d;
            last_addr_q <= last_addr_d;
            flush_req_q <= flush_req_d;
            cnt_q       <= cnt_d;
            wr_en_q     <= wr_en_d;
            addr_q      <= addr_d;
            dat_q       <= dat_d;
        end
    end

    assign bus.wr_en        = wr_en_q;
    assign bus.addr         = addr_q;
    assign bus.dat          = dat_q;
    assign bus.pend_vld     = p_vld_q;
    assign bus.pend_blocked = p_blk_q;

endmodule

// File: tb/tb_wr_combine.sv
// Bench for wr_combine: directed scenarios plus a randomized run, all
// compared cycle by cycle against a behavioural model of the combining rules.
module tb_wr_combine;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wr_combine_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    wr_combine #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural model state
    logic          m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_dat;
    logic          m_pv, m_pb, m_lv, m_fr;
    logic [AW-1:0] m_pa, m_la;
    logic [DW-1:0] m_pd;
    int            m_cnt;

    task automatic model_reset();
        m_wr = 0; m_addr = '0; m_dat = '0;
        m_pv = 0; m_pb = 0; m_lv = 0; m_fr = 0;
        m_pa = '0; m_la = '0; m_pd = '0; m_cnt = 0;
    endtask

    task automatic model_step(input logic v, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic f);
        logic run, exec, hit, clr, iss;
        logic [AW-1:0] ia;
        logic [DW-1:0] id;
        run  = !v && m_pv && !m_pb;
        exec = run && m_fr;
        hit  = run && (m_cnt == TO - 1) && !exec;
        clr  = !v && m_fr && (!m_pv || !m_pb);
        iss  = 0; ia = m_pa; id = m_pd;
        if (v) begin
            if (!m_pv) begin
                m_pv = 1; m_pa = a; m_pd = d; m_pb = m_lv && (a == m_la);
            end else if (a == m_pa) begin
                m_pd = d;
            end else if (!m_pb) begin
                iss = 1; m_pa = a; m_pd = d;
            end else begin
                iss = 1; ia = a; id = d; m_pb = 0;
            end
        end else if (exec) begin
            iss = 1; m_pv = 0; m_pb = 0;
        end
        m_fr  = f || hit || (m_fr && !clr);
        m_cnt = (run && !iss) ? m_cnt + 1 : 0;
        m_wr  = iss;
        if (iss) begin
            m_addr = ia; m_dat = id; m_lv = 1; m_la = ia;
        end
    endtask

    // Drive one cycle of stimulus; returns 1 time unit after the capturing edge.
    task automatic step(input logic v, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic f);
        bus.in_valid = v; bus.in_addr = a; bus.in_dat = d; bus.flush = f;
        @(posedge clk);
        model_step(v, a, d, f);
        #1;
        bus.in_valid = 0; bus.flush = 0;
    endtask

    // Model scoreboard on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ({bus.wr_en, bus.addr, bus.dat, bus.pend_vld, bus.pend_blocked} !==
                {m_wr, m_addr, m_dat, m_pv, m_pb}) begin
                errors++;
                $display("FAIL model_cmp t=%0t got wr=%b a=%0d d=%0d pv=%b pb=%b exp wr=%b a=%0d d=%0d pv=%b pb=%b",
                         $time, bus.wr_en, bus.addr, bus.dat, bus.pend_vld, bus.pend_blocked,
                         m_wr, m_addr, m_dat, m_pv, m_pb);
            end
        end
    end

    // No two successive pulses may carry the same address
    logic          inv_seen = 0;
    logic [AW-1:0] inv_prev;
    always @(negedge clk) begin
        if (rst) begin
            inv_seen = 0;
        end else if (bus.wr_en) begin
            checks++;
            if (inv_seen && bus.addr == inv_prev) begin
                errors++;
                $display("FAIL same_addr_pulse got addr=%0d prev=%0d required different", bus.addr, inv_prev);
            end
            inv_prev = bus.addr;
            inv_seen = 1;
        end
    end

    task automatic drain();
        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    endtask

    task automatic test_reset();
        bus.in_valid = 0; bus.in_addr = '0; bus.in_dat = '0; bus.flush = 0;
        rst = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.wr_en, bus.addr, bus.dat, bus.pend_vld, bus.pend_blocked} !== '0) begin
            errors++;
            $display("FAIL reset_state got wr=%b a=%0d d=%0d pv=%b pb=%b required all 0",
                     bus.wr_en, bus.addr, bus.dat, bus.pend_vld, bus.pend_blocked);
        end
        rst = 0;
    endtask

    task automatic test_flush_basic();
        step(1, 10, 100, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(1, 12, 200, 0);
        checks++;
        if ({bus.wr_en, bus.addr, bus.dat} !== {1'b1, 8'd10, 16'd100}) begin
            errors++;
            $display("FAIL flush_basic_first got wr=%b a=%0d d=%0d required 1/10/100", bus.wr_en, bus.addr, bus.dat);
        end
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        checks++;
        if ({bus.wr_en, bus.addr, bus.dat} !== {1'b1, 8'd12, 16'd200}) begin
            errors++;
            $display("FAIL flush_basic_second got wr=%b a=%0d d=%0d required 1/12/200", bus.wr_en, bus.addr, bus.dat);
        end
        step(0, 0, 0, 0);
        checks++;
        if (bus.wr_en !== 1'b0) begin
            errors++;
            $display("FAIL flush_basic_pulse_width got wr=%b required 0", bus.wr_en);
        end
    endtask

    task automatic test_merge();
        step(1, 10, 111, 0);
        step(1, 10, 222, 0);
        checks++;
        if (bus.wr_en !== 1'b0) begin
            errors++;
            $display("FAIL merge_no_pulse got wr=%b required 0", bus.wr_en);
        end
        step(1, 11, 5, 0);
        checks++;
        if ({bus.wr_en, bus.addr, bus.dat} !== {1'b1, 8'd10, 16'd222}) begin
            errors++;
            $display("FAIL merge_issue got wr=%b a=%0d d=%0d required 1/10/222", bus.wr_en, bus.addr, bus.dat);
        end
        drain();
    endtask

    task automatic test_blocked();
        int pulses;
        step(1, 10, 111, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(1, 10, 222, 0);
        pulses = 0;
        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            if (bus.wr_en) pulses++;
        end
        checks++;
        if (pulses != 0 || bus.pend_blocked !== 1'b1) begin
            errors++;
            $display("FAIL blocked_hold got pulses=%0d pb=%b required 0/1", pulses, bus.pend_blocked);
        end
        step(1, 11, 7, 0);
        checks++;
        if ({bus.wr_en, bus.addr, bus.dat, bus.pend_blocked} !== {1'b1, 8'd11, 16'd7, 1'b0}) begin
            errors++;
            $display("FAIL blocked_bypass got wr=%b a=%0d d=%0d pb=%b required 1/11/7/0",
                     bus.wr_en, bus.addr, bus.dat, bus.pend_blocked);
        end
        step(0, 0, 0, 1);
        checks++;
        if ({bus.wr_en, bus.addr, bus.dat} !== {1'b1, 8'd10, 16'd222}) begin
            errors++;
            $display("FAIL blocked_release got wr=%b a=%0d d=%0d required 1/10/222", bus.wr_en, bus.addr, bus.dat);
        end
        drain();
    endtask

    task automatic test_timeout();
        int hit_at, pulses;
        step(1, 20, 50, 0);
        hit_at = -1;
        for (int i = 1; i <= 14; i++) begin
            step(0, 0, 0, 0);
            if (bus.wr_en && hit_at < 0) hit_at = i;
        end
        checks++;
        if (hit_at != TO + 1 || bus.addr !== 8'd20 || bus.dat !== 16'd50) begin
            errors++;
            $display("FAIL timeout_latency got cycle=%0d a=%0d d=%0d required %0d/20/50",
                     hit_at, bus.addr, bus.dat, TO + 1);
        end
        step(1, 20, 1, 0);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            step(0, 0, 0, 0);
            if (bus.wr_en) pulses++;
        end
        checks++;
        if (pulses != 0 || bus.pend_blocked !== 1'b1) begin
            errors++;
            $display("FAIL timeout_blocked got pulses=%0d pb=%b required 0/1", pulses, bus.pend_blocked);
        end
        step(1, 21, 2, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0);
        checks++;
        if (bus.pend_vld !== 1'b0 || bus.addr !== 8'd20 || bus.dat !== 16'd1) begin
            errors++;
            $display("FAIL timeout_after_unblock got pv=%b a=%0d d=%0d required 0/20/1", bus.pend_vld, bus.addr, bus.dat);
        end
    endtask

    task automatic test_same_cycle();
        step(1, 29, 9, 0);
        step(1, 30, 3, 1);
        checks++;
        if ({bus.wr_en, bus.addr, bus.dat} !== {1'b1, 8'd29, 16'd9}) begin
            errors++;
            $display("FAIL same_cycle_arrival got wr=%b a=%0d d=%0d required 1/29/9", bus.wr_en, bus.addr, bus.dat);
        end
        step(0, 0, 0, 0);
        checks++;
        if ({bus.wr_en, bus.addr, bus.dat, bus.pend_vld} !== {1'b1, 8'd30, 16'd3, 1'b0}) begin
            errors++;
            $display("FAIL same_cycle_flush got wr=%b a=%0d d=%0d pv=%b required 1/30/3/0",
                     bus.wr_en, bus.addr, bus.dat, bus.pend_vld);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        step(1, 40, 1, 0);
        #2 rst = 1;
        model_reset();
        #1;
        checks++;
        if ({bus.wr_en, bus.addr, bus.dat, bus.pend_vld, bus.pend_blocked} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs got wr=%b a=%0d d=%0d pv=%b pb=%b required all 0",
                     bus.wr_en, bus.addr, bus.dat, bus.pend_vld, bus.pend_blocked);
        end
        @(posedge clk);
        #1 rst = 0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, (i == 2));
            if (bus.wr_en) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_discard got pulses=%0d required 0", bad);
        end
    endtask

    task automatic test_random();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(99) < 75), AW'($urandom_range(3)), DW'($urandom), ($urandom_range(99) < 10));
            if (bus.wr_en) pulses++;
        end
        drain();
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0);
        checks++;
        if (pulses == 0) begin
            errors++;
            $display("FAIL random_activity got pulses=%0d required >0", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_flush_basic();
        test_merge();
        test_blocked();
        test_timeout();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
